// File: rtl/regfile_pkg.sv
// Shared register-file widths, R0 index and write-arbiter FSM encoding.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 5;
  localparam int R0_IDX = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_LO = 2'd1,
    PEND_HI = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write path between writeback (always wins) and one buffered
// 32-bit MDU result, written as lo->dest then hi->R0; raises stall_req when the MDU starves.
module regfile_write_arbiter #(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int REG_AW     = regfile_pkg::REG_AW,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [REG_AW-1:0]   mdu_reg,
  input  logic [2*DATA_W-1:0] mdu_result,
  output logic                rf_reg_write,
  output logic [REG_AW-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_write_r0,
  output logic [DATA_W-1:0]   rf_r0,
  output logic                stall_req,
  output logic                busy
);
  import regfile_pkg::*;

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [REG_AW-1:0] R0_REG  = REG_AW'(R0_IDX);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              hi_kill_q, hi_kill_d;
  logic              wb_hits_lo, wb_hits_r0;

  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign wb_hits_lo = wb_we && (wb_reg == reg_q);
  assign wb_hits_r0 = wb_we && (wb_reg == R0_REG);

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    reg_d     = reg_q;
    cnt_d     = cnt_q;
    hi_kill_d = hi_kill_q;
    unique case (state_q)
      IDLE: begin
        if (mdu_valid) begin
          lo_d      = mdu_result[DATA_W-1:0];
          hi_d      = mdu_result[2*DATA_W-1:DATA_W];
          reg_d     = mdu_reg;
          cnt_d     = '0;
          hi_kill_d = 1'b0;
          state_d   = PEND_LO;
        end
      end
      PEND_LO: begin
        if (wb_we) begin
          // A younger writeback to the same register makes the pending write stale.
          cnt_d = cnt_inc;
          if (wb_hits_lo && (wb_hits_r0 || hi_kill_q)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hi_kill_d = 1'b0;
          end else if (wb_hits_lo) begin
            state_d   = PEND_HI;
          end else if (wb_hits_r0) begin
            hi_kill_d = 1'b1;
          end
        end else begin
          cnt_d     = '0;
          hi_kill_d = 1'b0;
          state_d   = hi_kill_q ? IDLE : PEND_HI;
        end
      end
      PEND_HI: begin
        if (wb_we && !wb_hits_r0) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      reg_q     <= '0;
      cnt_q     <= '0;
      hi_kill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      reg_q     <= reg_d;
      cnt_q     <= cnt_d;
      hi_kill_q <= hi_kill_d;
    end
  end

  // All outputs are forced low while reset is held, including mdu_ready.
  always_comb begin
    mdu_ready     = 1'b0;
    busy          = 1'b0;
    stall_req     = 1'b0;
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_write_r0   = 1'b0;
    rf_r0         = '0;
    if (!reset) begin
      mdu_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      stall_req = (state_q != IDLE) && (cnt_q == CNT_MAX);
      if (wb_we) begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = wb_reg;
        rf_write_data = wb_data;
      end else if (state_q == PEND_LO) begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = reg_q;
        rf_write_data = lo_q;
      end else if (state_q == PEND_HI) begin
        rf_write_r0 = 1'b1;
        rf_r0       = hi_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a pending-write model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [15:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_result;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [15:0] rf_write_data;
  logic        rf_write_r0;
  logic [15:0] rf_r0;
  logic        stall_req;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Reference model: which halves are still owed, the buffered result, and the blocked-cycle run.
  logic        m_lo, m_hi;
  logic [15:0] m_lo_v, m_hi_v;
  logic [4:0]  m_reg;
  int          m_starve;
  logic        last_stall;

  // Register file as seen through the DUT's strobes (reg_write wins over write_r0).
  logic [15:0] rf [32];

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_result(mdu_result),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_write_r0(rf_write_r0), .rf_r0(rf_r0), .stall_req(stall_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input logic ready_exp);
    chk({tag, "_ready"}, 32'(mdu_ready), 32'(ready_exp));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stall"}, 32'(stall_req), 32'd0);
    chk({tag, "_regwr"}, 32'(rf_reg_write), 32'd0);
    chk({tag, "_r0wr"}, 32'(rf_write_r0), 32'd0);
    chk({tag, "_wreg"}, 32'(rf_write_reg), 32'd0);
    chk({tag, "_wdata"}, 32'(rf_write_data), 32'd0);
    chk({tag, "_r0"}, 32'(rf_r0), 32'd0);
  endtask

  task automatic cyc(input logic we, input logic [4:0] wr, input logic [15:0] wd,
                     input logic mv, input logic [4:0] mr, input logic [31:0] mres);
    logic        pend, e_we, e_r0;
    logic [4:0]  e_reg;
    logic [15:0] e_dat, e_r0v;
    logic        s_we, s_r0;
    logic [4:0]  s_reg;
    logic [15:0] s_dat, s_r0v;
    @(negedge clk);
    wb_we = we; wb_reg = wr; wb_data = wd;
    mdu_valid = mv; mdu_reg = mr; mdu_result = mres;
    #1;
    pend  = m_lo || m_hi;
    e_we  = 1'b0; e_r0 = 1'b0; e_reg = '0; e_dat = '0; e_r0v = '0;
    if (we) begin
      e_we = 1'b1; e_reg = wr; e_dat = wd;
    end else if (m_lo) begin
      e_we = 1'b1; e_reg = m_reg; e_dat = m_lo_v;
    end else if (m_hi) begin
      e_r0 = 1'b1; e_r0v = m_hi_v;
    end
    chk("mdu_ready", 32'(mdu_ready), 32'(!pend));
    chk("busy", 32'(busy), 32'(pend));
    chk("stall_req", 32'(stall_req), 32'(pend && m_starve >= 3));
    chk("rf_reg_write", 32'(rf_reg_write), 32'(e_we));
    chk("rf_write_reg", 32'(rf_write_reg), 32'(e_reg));
    chk("rf_write_data", 32'(rf_write_data), 32'(e_dat));
    chk("rf_write_r0", 32'(rf_write_r0), 32'(e_r0));
    chk("rf_r0", 32'(rf_r0), 32'(e_r0v));
    last_stall = stall_req;
    s_we = rf_reg_write; s_reg = rf_write_reg; s_dat = rf_write_data;
    s_r0 = rf_write_r0; s_r0v = rf_r0;
    @(posedge clk);
    if (s_we) rf[s_reg] = s_dat;
    else if (s_r0) rf[0] = s_r0v;
    if (!pend) begin
      if (mv) begin
        m_lo = 1'b1; m_hi = 1'b1;
        m_lo_v = mres[15:0]; m_hi_v = mres[31:16]; m_reg = mr; m_starve = 0;
      end
    end else if (we) begin
      m_starve = (m_starve < 3) ? m_starve + 1 : 3;
      if (m_lo && wr == m_reg) m_lo = 1'b0;
      if (wr == 5'd0) m_hi = 1'b0;
    end else begin
      if (m_lo) m_lo = 1'b0;
      else      m_hi = 1'b0;
      m_starve = 0;
    end
    if (!m_lo && !m_hi) m_starve = 0;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic accept(input logic [4:0] mr, input logic [31:0] mres);
    cyc(1'b0, 5'd0, 16'd0, 1'b1, mr, mres);
  endtask

  task automatic wb(input logic [4:0] wr, input logic [15:0] wd);
    cyc(1'b1, wr, wd, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_reg = 0; wb_data = 0; mdu_valid = 0; mdu_reg = 0; mdu_result = 0;
    m_lo = 0; m_hi = 0; m_lo_v = 0; m_hi_v = 0; m_reg = 0; m_starve = 0; last_stall = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    #2;
    chk_all_zero("reset_hold", 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_release", 1'b1);

    // Idle accept: lo at T+1, hi at T+2, ready at T+3.
    accept(5'd5, 32'h1234_ABCD);
    idle();
    chk("accept_R5", 32'(rf[5]), 32'h0000_ABCD);
    idle();
    chk("accept_R0", 32'(rf[0]), 32'h0000_1234);
    idle();

    // Writeback priority defers both MDU writes by two cycles.
    accept(5'd6, 32'h4321_5678);
    wb(5'd3, 16'h7B18);
    wb(5'd3, 16'h7B18);
    chk("prio_R3", 32'(rf[3]), 32'h0000_7B18);
    chk("prio_R6_deferred", 32'(rf[6]), 32'h0000_0000);
    idle();
    chk("prio_R6", 32'(rf[6]), 32'h0000_5678);
    idle();
    chk("prio_R0", 32'(rf[0]), 32'h0000_4321);
    idle();

    // Starvation: stall_req appears in the 4th blocked cycle.
    accept(5'd7, 32'h0BAD_F00D);
    wb(5'd8, 16'h0001);
    wb(5'd8, 16'h0002);
    wb(5'd8, 16'h0003);
    chk("starve_3rd", 32'(last_stall), 32'd0);
    wb(5'd8, 16'h0004);
    chk("starve_4th", 32'(last_stall), 32'd1);
    idle();
    chk("starve_lo", 32'(rf[7]), 32'h0000_F00D);
    idle();
    chk("starve_hi", 32'(rf[0]), 32'h0000_0BAD);
    idle();

    // WAW squash of lo, then of hi.
    accept(5'd5, 32'hAAAA_BBBB);
    wb(5'd5, 16'h0051);
    wb(5'd0, 16'hC0DE);
    idle();
    idle();
    chk("waw_R5", 32'(rf[5]), 32'h0000_0051);
    chk("waw_R0", 32'(rf[0]), 32'h0000_C0DE);

    // Destination R0: lo then hi overwrite.
    accept(5'd0, 32'hFFFF_0002);
    idle();
    chk("r0dest_lo", 32'(rf[0]), 32'h0000_0002);
    idle();
    chk("r0dest_hi", 32'(rf[0]), 32'h0000_FFFF);
    idle();

    // Reset while PEND_HI: the hi write is discarded.
    accept(5'd9, 32'h5555_6666);
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_mid", 1'b0);
    m_lo = 0; m_hi = 0; m_starve = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_after", 1'b1);
    chk("reset_R9", 32'(rf[9]), 32'h0000_6666);
    chk("reset_R0_kept", 32'(rf[0]), 32'h0000_FFFF);
    idle();
    chk("reset_R0_final", 32'(rf[0]), 32'h0000_FFFF);

    // Randomized traffic with a small register range to provoke squashes.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 2) == 0, 5'($urandom_range(0, 6)), 16'($urandom),
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 6)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
